// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: ROM port, redirect request, decode handshake and status.
// Handshake: a head entry transfers when out_valid && out_ready are both high at a rising clk edge
// and no redirect is sampled in that same cycle.
interface instr_fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]    rom_data;
    logic                     redir_valid;
    logic [ADDRESS_WIDTH+1:0] redir_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_instr;
    logic [ADDRESS_WIDTH+1:0] out_pc;
    logic                     halted;
    logic [1:0]               dbg_state;

    modport master (
        input  start, rom_data, redir_valid, redir_pc, out_ready,
        output rom_addr, out_valid, out_instr, out_pc, halted, dbg_state
    );

    modport slave (
        output start, rom_data, redir_valid, redir_pc, out_ready,
        input  rom_addr, out_valid, out_instr, out_pc, halted, dbg_state
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: drives a combinational ROM, buffers {pc, instr} in a
// 2-entry FIFO toward decode, handles redirect flushes and stops on the halt word.
module instr_fetch_ctrl #(
    parameter int          ADDRESS_WIDTH = 8,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] HALT_WORD     = 32'h0000_006F
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [1:0]               count_q, count_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0]    instr_q [2];
    logic [ADDRESS_WIDTH-1:0] pc_q    [2];

    logic redirect;
    logic push;
    logic pop;
    logic unused_redir_lsbs;

    assign unused_redir_lsbs = ^bus.redir_pc[1:0];

    // Redirect outranks both FIFO ports; IDLE ignores it entirely.
    assign redirect = bus.redir_valid && (state_q != S_IDLE);
    assign pop      = (count_q != 2'd0) && bus.out_ready && !redirect;
    assign push     = (state_q == S_RUN) && !bus.redir_valid && ((count_q != 2'd2) || pop);

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (state_q == S_IDLE) begin
            if (bus.start) begin
                state_d     = S_RUN;
                fetch_ptr_d = '0;
            end
        end else if (redirect) begin
            state_d     = S_RUN;
            fetch_ptr_d = bus.redir_pc[ADDRESS_WIDTH+1:2];
            count_d     = 2'd0;
            rd_ptr_d    = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d    = ~wr_ptr_q;
                fetch_ptr_d = fetch_ptr_q + 1'b1;
                if (bus.rom_data == HALT_WORD) state_d = S_HALTED;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_ptr_q <= '0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            instr_q[0]  <= '0;
            instr_q[1]  <= '0;
            pc_q[0]     <= '0;
            pc_q[1]     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (push) begin
                instr_q[wr_ptr_q] <= bus.rom_data;
                pc_q[wr_ptr_q]    <= fetch_ptr_q;
            end
        end
    end

    // Decode sees only FIFO registers; an empty FIFO leaves the stale head on out_*.
    assign bus.rom_addr  = fetch_ptr_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = instr_q[rd_ptr_q];
    assign bus.out_pc    = {pc_q[rd_ptr_q], 2'b00};
    assign bus.halted    = (state_q == S_HALTED);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl plus a short random-handshake run against a stream model.
module tb_instr_fetch_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  logic [DW-1:0] rom [256];
  int checks;
  int errors;

  instr_fetch_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .HALT_WORD(32'h0000_006F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [9:0] pc);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_pc"}, 64'(bus.out_pc), 64'(pc));
    check({tag, "_instr"}, 64'(bus.out_instr), 64'(rom[pc[9:2]]));
  endtask

  task automatic redirect(input logic [9:0] pc);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = pc;
    step();
    bus.redir_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] exp_pc;
    int delivered;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0100_0000 + 32'(i) + 32'd1;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;
    bus.out_ready   = 1'b0;
    step();
    step();
    check("rst_addr",   64'(bus.rom_addr),  64'd0);
    check("rst_valid",  64'(bus.out_valid), 64'd0);
    check("rst_instr",  64'(bus.out_instr), 64'd0);
    check("rst_pc",     64'(bus.out_pc),    64'd0);
    check("rst_halted", 64'(bus.halted),    64'd0);
    rst_n = 1'b1;
    step();

    // IDLE ignores redirect
    redirect(10'h080);
    check("idle_redir_addr",  64'(bus.rom_addr),  64'd0);
    check("idle_redir_valid", 64'(bus.out_valid), 64'd0);

    // 1: start, one instruction per cycle
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    check("t1_first_valid", 64'(bus.out_valid), 64'd0);
    check("t1_first_addr",  64'(bus.rom_addr),  64'd0);
    step();
    check_head("t1_w0", 10'h000);
    check("t1_addr1", 64'(bus.rom_addr), 64'd1);
    for (int k = 1; k < 6; k++) begin
      step();
      check_head("t1_stream", 10'(4 * k));
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", 64'(bus.out_valid), 64'd0);
    check("t1_async_addr",  64'(bus.rom_addr),  64'd0);
    check("t1_async_pc",    64'(bus.out_pc),    64'd0);
    step();
    rst_n = 1'b1;

    // 2: backpressure
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_head("t2_hold", 10'h000);
    check("t2_addr_stall", 64'(bus.rom_addr), 64'd2);
    bus.out_ready = 1'b1;
    step();
    check_head("t2_w1", 10'h004);
    step();
    check_head("t2_w2", 10'h008);
    step();
    check_head("t2_w3", 10'h00C);

    // 3: redirect while full, head not accepted
    bus.out_ready = 1'b0;
    step();
    check("t3_full_addr", 64'(bus.rom_addr), 64'd5);
    bus.out_ready = 1'b1;
    redirect(10'h040);
    check("t3_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t3_flush_addr",  64'(bus.rom_addr),  64'd16);
    step();
    check_head("t3_w16", 10'h040);
    redirect(10'h043);
    check("t3_lsb_addr",  64'(bus.rom_addr),  64'd16);
    check("t3_lsb_valid", 64'(bus.out_valid), 64'd0);
    step();
    check_head("t3_lsb_w16", 10'h040);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 10'h080;
    step();
    bus.redir_pc = 10'h100;
    step();
    bus.redir_valid = 1'b0;
    check("t3_b2b_addr",  64'(bus.rom_addr),  64'd64);
    check("t3_b2b_valid", 64'(bus.out_valid), 64'd0);
    step();
    check_head("t3_b2b_w64", 10'h100);

    // 4: halt word at ROM[5]
    do_reset();
    rom[5] = 32'h0000_006F;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_head("t4_stream", 10'(4 * k));
    end
    check("t4_halted", 64'(bus.halted),   64'd1);
    check("t4_addr6",  64'(bus.rom_addr), 64'd6);
    step();
    check("t4_drained", 64'(bus.out_valid), 64'd0);
    step();
    check("t4_addr_frozen", 64'(bus.rom_addr), 64'd6);
    check("t4_still_halt",  64'(bus.halted),   64'd1);
    redirect(10'h008);
    check("t4_resume_halted", 64'(bus.halted),   64'd0);
    check("t4_resume_addr",   64'(bus.rom_addr), 64'd2);
    step();
    check_head("t4_resume_w2", 10'h008);
    rom[5] = 32'h0100_0006;

    // 5: wrap
    redirect(10'h3F8);
    step();
    check_head("t5_w254", 10'h3F8);
    step();
    check_head("t5_w255", 10'h3FC);
    step();
    check_head("t5_w0", 10'h000);
    step();
    check_head("t5_w1", 10'h004);

    // 6: random ready / redirects against the expected stream
    exp_pc    = 10'h004;
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.redir_valid = ($urandom_range(0, 15) == 0);
      bus.redir_pc    = 10'($urandom_range(0, 1023));
      if (bus.redir_valid) begin
        exp_pc = {bus.redir_pc[9:2], 2'b00};
      end else if (bus.out_valid && bus.out_ready) begin
        check("t6_pc",    64'(bus.out_pc),    64'(exp_pc));
        check("t6_instr", 64'(bus.out_instr), 64'(rom[exp_pc[9:2]]));
        exp_pc = exp_pc + 10'd4;
        delivered++;
      end
      step();
    end
    bus.redir_valid = 1'b0;
    check("t6_progress", 64'(delivered > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
